// File: rtl/upload_arbiter_pkg.sv
// Shared types and constants for the upload arbiter (upload_arbiter and its
// round-robin picker). Channel indices are always CH_IDX_W bits wide so that
// any channel count up to MAX_CH shares one index type.
package upload_arbiter_pkg;

  localparam int UPLOAD_DATA_W = 8;
  localparam int UPLOAD_SRC_W  = 8;
  localparam int MAX_CH        = 8;
  localparam int CH_IDX_W      = 3;
  localparam int SUM_W         = CH_IDX_W + 1;

  // Arbiter FSM: IDLE picks a channel, LOCK owns it, DRAIN flushes the
  // output register before the rotation pointer moves.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // Folds last_grant + offset back into 0..num_ch-1. The sum never
  // exceeds 2*num_ch-1, so one conditional subtraction is enough.
  function automatic logic [CH_IDX_W-1:0] wrap_idx(input logic [SUM_W-1:0] sum,
                                                   input int num_ch);
    logic [SUM_W-1:0] r;
    r = sum;
    if (int'(sum) >= num_ch) r = sum - SUM_W'(num_ch);
    return r[CH_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/upload_arbiter_rr_picker.sv
// Combinational round-robin chooser: returns the first requesting channel
// strictly after last_grant (wrapping modulo NUM_CH) and whether any
// channel requests at all.
module upload_arbiter_rr_picker
  import upload_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]   req,
  input  logic [CH_IDX_W-1:0] last_grant,
  output logic [CH_IDX_W-1:0] grant,
  output logic                any
);

  logic [MAX_CH-1:0]   req_ext;
  logic [CH_IDX_W-1:0] cand;

  assign req_ext = MAX_CH'(req);

  // Scan offsets from the farthest to the nearest so the channel closest
  // after last_grant is the final (winning) assignment.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = wrap_idx({1'b0, last_grant} + SUM_W'(k), NUM_CH);
      if (req_ext[cand]) begin
        grant = cand;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/upload_arbiter.sv
// upload_arbiter: merges NUM_CH packed upload streams onto one USB upload
// channel. A channel is granted per frame (round-robin) and keeps the
// output until its req drops, so frames never interleave. Bytes pass
// through a single output register (1 cycle latency, full throughput).
//
// Optional feature, enabled by defining UPLOAD_ARB_TIMEOUT_EN: a watchdog
// revokes the grant after TIMEOUT_CYC cycles in LOCK without an accepted
// byte and pulses timeout_flag for one cycle.
//
// Handshake: on every interface a byte moves on a rising clk edge where
// valid && ready are both high; valid and data/source stay stable until
// that edge, and ready may depend combinationally on the downstream ready.
module upload_arbiter
  import upload_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4
`ifdef UPLOAD_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          in_upload_req,
  input  logic [8*NUM_CH-1:0]        in_upload_data,
  input  logic [8*NUM_CH-1:0]        in_upload_source,
  input  logic [NUM_CH-1:0]          in_upload_valid,
  output logic [NUM_CH-1:0]          in_upload_ready,
  output logic                       merged_upload_req,
  output logic [UPLOAD_DATA_W-1:0]   merged_upload_data,
  output logic [UPLOAD_SRC_W-1:0]    merged_upload_source,
  output logic                       merged_upload_valid,
  input  logic                       merged_upload_ready,
  output logic [CH_IDX_W-1:0]        active_ch,
  output logic [1:0]                 dbg_state
`ifdef UPLOAD_ARB_TIMEOUT_EN
  , output logic                     timeout_flag
`endif
);

  arb_state_t              state_q, state_d;
  logic [CH_IDX_W-1:0]     grant_q, grant_d;
  logic [CH_IDX_W-1:0]     last_grant_q, last_grant_d;
  logic                    out_valid_q, out_valid_d;
  logic [UPLOAD_DATA_W-1:0] out_data_q, out_data_d;
  logic [UPLOAD_SRC_W-1:0]  out_src_q, out_src_d;

  logic [CH_IDX_W-1:0]     pick;
  logic                    pick_any;
  logic                    sel_req, sel_valid;
  logic [UPLOAD_DATA_W-1:0] sel_data;
  logic [UPLOAD_SRC_W-1:0]  sel_src;
  logic                    lock_open;
  logic                    take;

`ifdef UPLOAD_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0]         wd_cnt_q, wd_cnt_d;
  logic                    timeout_q, timeout_d;
`endif

  upload_arbiter_rr_picker #(
    .NUM_CH (NUM_CH)
  ) u_picker (
    .req        (in_upload_req),
    .last_grant (last_grant_q),
    .grant      (pick),
    .any        (pick_any)
  );

  // Input mux: only the granted channel's signals reach the FSM and output stage.
  always_comb begin
    sel_req   = 1'b0;
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_src   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_q == CH_IDX_W'(i)) begin
        sel_req   = in_upload_req[i];
        sel_valid = in_upload_valid[i];
        sel_data  = in_upload_data[8*i +: 8];
        sel_src   = in_upload_source[8*i +: 8];
      end
    end
  end

  // The output register can take a byte when empty or being emptied this cycle.
  assign lock_open = (state_q == LOCK) && (!out_valid_q || merged_upload_ready);
  assign take      = lock_open && sel_valid;

  // Per-channel ready: only the granted channel ever sees ready.
  always_comb begin
    in_upload_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_upload_ready[i] = lock_open && (grant_q == CH_IDX_W'(i));
    end
  end

  // Next-state logic: grant selection, frame ownership and drain.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
`ifdef UPLOAD_ARB_TIMEOUT_EN
    timeout_d    = 1'b0;
    wd_cnt_d     = '0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick;
          state_d = LOCK;
        end
      end
      LOCK: begin
`ifdef UPLOAD_ARB_TIMEOUT_EN
        if (!take) wd_cnt_d = wd_cnt_q + 1'b1;
`endif
        // A byte still valid after req drops is accepted before leaving.
        if (!sel_req && !sel_valid) begin
          state_d = DRAIN;
        end
`ifdef UPLOAD_ARB_TIMEOUT_EN
        else if (!take && (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1))) begin
          state_d   = DRAIN;
          timeout_d = 1'b1;
        end
`endif
      end
      DRAIN: begin
        // Rotation advances only once the last byte of the frame has left.
        if (!out_valid_q) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: load on input transfer, clear on downstream accept, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_src_d   = sel_src;
    end else if (merged_upload_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers; reset drops any held byte and restarts rotation at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= CH_IDX_W'(NUM_CH - 1);
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
    end
  end

`ifdef UPLOAD_ARB_TIMEOUT_EN
  // Watchdog counter and one-cycle timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_flag = timeout_q;
`endif

  assign merged_upload_valid  = out_valid_q;
  assign merged_upload_data   = out_data_q;
  assign merged_upload_source = out_src_q;
  assign merged_upload_req    = (state_q != IDLE) || out_valid_q;
  assign active_ch            = grant_q;
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_upload_arbiter.sv
// Bench for upload_arbiter: directed frame scenarios plus randomized
// multi-channel traffic against a frame-level reference model.
module tb_upload_arbiter;

  localparam int NUM_CH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]   in_upload_req;
  logic [8*NUM_CH-1:0] in_upload_data;
  logic [8*NUM_CH-1:0] in_upload_source;
  logic [NUM_CH-1:0]   in_upload_valid;
  logic [NUM_CH-1:0]   in_upload_ready;
  logic                merged_upload_req;
  logic [7:0]          merged_upload_data;
  logic [7:0]          merged_upload_source;
  logic                merged_upload_valid;
  logic                merged_upload_ready;
  logic [2:0]          active_ch;
  logic [1:0]          dbg_state;
`ifdef UPLOAD_ARB_TIMEOUT_EN
  logic                timeout_flag;
`endif

  upload_arbiter #(
    .NUM_CH (NUM_CH)
`ifdef UPLOAD_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC (16)
`endif
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_upload_req        (in_upload_req),
    .in_upload_data       (in_upload_data),
    .in_upload_source     (in_upload_source),
    .in_upload_valid      (in_upload_valid),
    .in_upload_ready      (in_upload_ready),
    .merged_upload_req    (merged_upload_req),
    .merged_upload_data   (merged_upload_data),
    .merged_upload_source (merged_upload_source),
    .merged_upload_valid  (merged_upload_valid),
    .merged_upload_ready  (merged_upload_ready),
    .active_ch            (active_ch),
    .dbg_state            (dbg_state)
`ifdef UPLOAD_ARB_TIMEOUT_EN
    , .timeout_flag       (timeout_flag)
`endif
  );

  // Per-channel stimulus, packed onto the DUT ports.
  logic       ch_req[NUM_CH];
  logic       ch_valid[NUM_CH];
  logic [7:0] ch_data[NUM_CH];
  logic [7:0] ch_src[NUM_CH];

  always_comb begin
    in_upload_req    = '0;
    in_upload_valid  = '0;
    in_upload_data   = '0;
    in_upload_source = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      in_upload_req[c]          = ch_req[c];
      in_upload_valid[c]        = ch_valid[c];
      in_upload_data[8*c +: 8]  = ch_data[c];
      in_upload_source[8*c +: 8] = ch_src[c];
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- downstream ready driver ----------------
  int   ready_mode = 0;   // 0: always ready, 1: pattern 1,0,0,1, 2: random 75%
  int   pidx = 0;
  logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    merged_upload_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          merged_upload_ready = pat[pidx % 4];
          pidx++;
        end
        2: merged_upload_ready = ($urandom_range(0, 3) != 0);
        default: merged_upload_ready = 1'b1;
      endcase
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [18:0] exp_q[$];      // {channel, source, data} in acceptance order
  logic [2:0]  grant_log[$];  // granted channels, in grant order
  int          model_last = NUM_CH - 1;
  int          model_cur  = 0;
  bit          prev_idle  = 1'b0;
  logic [NUM_CH-1:0] prev_req = '0;
  bit          hold_pending = 1'b0;
  logic [7:0]  hold_data, hold_src;
  int          out_cnt = 0;

  // Round-robin rule: first requesting channel after 'last', wrapping.
  function automatic logic [2:0] rr_pick(input logic [NUM_CH-1:0] r, input int last);
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (last + k) % NUM_CH;
      if (r[c]) return 3'(c);
    end
    return 3'd7;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_idle    = 1'b0;
      hold_pending = 1'b0;
    end else begin
      logic [2:0]        exp_g;
      logic [18:0]       e;
      logic [NUM_CH-1:0] allowed;
      // A grant is taken on the edge after an idle cycle; check its choice.
      if (prev_idle && merged_upload_req) begin
        exp_g = rr_pick(prev_req, model_last);
        n_cmp++;
        if (active_ch !== exp_g) begin
          n_fail++;
          $display("FAIL grant_order: active_ch=%0d expected=%0d (req=%b last=%0d)",
                   active_ch, exp_g, prev_req, model_last);
        end
        grant_log.push_back(active_ch);
        model_cur  = int'(exp_g);
        model_last = int'(exp_g);
      end
      prev_idle = !merged_upload_req;
      prev_req  = in_upload_req;

      // Only the granted channel may see ready, and only while a frame is owned.
      allowed = '0;
      if (merged_upload_req && model_cur < NUM_CH) allowed[model_cur] = 1'b1;
      n_cmp++;
      if ((in_upload_ready & ~allowed) !== '0) begin
        n_fail++;
        $display("FAIL ready_exclusive: in_upload_ready=%b allowed=%b", in_upload_ready, allowed);
      end

      // A stalled output byte must stay valid and unchanged.
      if (hold_pending) begin
        n_cmp++;
        if (merged_upload_valid !== 1'b1 || merged_upload_data !== hold_data ||
            merged_upload_source !== hold_src) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%b data=%h src=%h expected valid=1 data=%h src=%h",
                   merged_upload_valid, merged_upload_data, merged_upload_source,
                   hold_data, hold_src);
        end
      end
      hold_pending = merged_upload_valid && !merged_upload_ready;
      hold_data    = merged_upload_data;
      hold_src     = merged_upload_source;

      // Output byte leaving this edge must be the oldest accepted input byte.
      if (merged_upload_valid && merged_upload_ready) begin
        out_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_byte: unexpected byte ch=%0d src=%h data=%h, expected none",
                   active_ch, merged_upload_source, merged_upload_data);
        end else begin
          e = exp_q.pop_front();
          if ({active_ch, merged_upload_source, merged_upload_data} !== e) begin
            n_fail++;
            $display("FAIL out_byte: got ch=%0d src=%h data=%h expected ch=%0d src=%h data=%h",
                     active_ch, merged_upload_source, merged_upload_data,
                     e[18:16], e[15:8], e[7:0]);
          end
        end
      end

      // Record input bytes accepted on the coming edge.
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_valid[c] && in_upload_ready[c])
          exp_q.push_back({3'(c), ch_src[c], ch_data[c]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_accept(input int c, output bit ok, output int tries);
    ok    = 1'b0;
    tries = 0;
    while (!ok && tries < 2000) begin
      @(negedge clk);
      ok = in_upload_ready[c];
      @(posedge clk);
      #1;
      tries++;
    end
  endtask

  task automatic drive_frame(input int c, input int nbytes, input int gap_max);
    bit ok;
    int tries;
    ch_req[c] = 1'b1;
    for (int b = 0; b < nbytes; b++) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
      ch_data[c]  = 8'($urandom);
      ch_src[c]   = 8'($urandom);
      ch_valid[c] = 1'b1;
      wait_accept(c, ok, tries);
      ch_valid[c] = 1'b0;
      if (!ok) begin
        n_cmp++;
        n_fail++;
        $display("FAIL accept_timeout: ch %0d byte %0d not accepted after %0d cycles", c, b, tries);
        ch_req[c] = 1'b0;
        return;
      end
    end
    ch_req[c] = 1'b0;
  endtask

  task automatic chan_run(input int c, input int nframes, input int max_bytes,
                          input int gap_max, input int idle_max);
    for (int f = 0; f < nframes; f++) begin
      drive_frame(c, $urandom_range(1, max_bytes), gap_max);
      repeat ($urandom_range(1, idle_max)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic settle(input string name);
    int quiet = 0;
    int cyc   = 0;
    while (quiet < 3 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (!merged_upload_req) quiet++;
      else quiet = 0;
    end
    n_cmp++;
    if (quiet < 3) begin
      n_fail++;
      $display("FAIL %s_settle: merged_upload_req still high after %0d cycles, expected low", name, cyc);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: %0d bytes undelivered, expected 0", name, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    model_last = NUM_CH - 1;
    model_cur  = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if ({merged_upload_req, merged_upload_valid, merged_upload_data, merged_upload_source,
         active_ch, in_upload_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b valid=%b data=%h src=%h ch=%0d ready=%b, expected all 0",
               merged_upload_req, merged_upload_valid, merged_upload_data,
               merged_upload_source, active_ch, in_upload_ready);
    end
    n_cmp++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: dbg_state=%0d expected 0", dbg_state);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (merged_upload_req !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_no_req: req=%b state=%0d expected req=0 state=0", merged_upload_req, dbg_state);
    end
  endtask

  task automatic test_single();
    bit ok;
    int tries;
    logic [7:0] exp_d;
    apply_reset();
    ch_req[0] = 1'b1;
    for (int b = 0; b < 3; b++) begin
      exp_d       = 8'hA1 + 8'(b);
      ch_data[0]  = exp_d;
      ch_src[0]   = 8'h01;
      ch_valid[0] = 1'b1;
      wait_accept(0, ok, tries);
      n_cmp++;
      if (!ok || merged_upload_valid !== 1'b1 || merged_upload_data !== exp_d ||
          merged_upload_source !== 8'h01) begin
        n_fail++;
        $display("FAIL single_latency: byte %0d valid=%b data=%h src=%h expected valid=1 data=%h src=01",
                 b, merged_upload_valid, merged_upload_data, merged_upload_source, exp_d);
      end
      if (b > 0) begin
        n_cmp++;
        if (tries !== 1) begin
          n_fail++;
          $display("FAIL single_throughput: byte %0d took %0d cycles, expected 1", b, tries);
        end
      end
    end
    ch_valid[0] = 1'b0;
    ch_req[0]   = 1'b0;
    settle("single");
  endtask

  task automatic test_two_req();
    apply_reset();
    grant_log.delete();
    fork
      drive_frame(0, 2, 0);
      drive_frame(2, 2, 0);
    join
    settle("two_req");
    n_cmp++;
    if (grant_log.size() != 2 || grant_log[0] !== 3'd0 || grant_log[1] !== 3'd2) begin
      n_fail++;
      $display("FAIL two_req_order: %0d grants (first=%0d), expected 2 grants 0 then 2",
               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : 3'd7);
    end
  endtask

  task automatic test_all_req();
    apply_reset();
    grant_log.delete();
    fork
      chan_run(0, 2, 1, 0, 1);
      chan_run(1, 2, 1, 0, 1);
      chan_run(2, 2, 1, 0, 1);
      chan_run(3, 2, 1, 0, 1);
    join
    settle("all_req");
    n_cmp++;
    if (grant_log.size() != 8) begin
      n_fail++;
      $display("FAIL all_req_count: %0d grants, expected 8", grant_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (grant_log[i] !== 3'(i % 4)) begin
          n_fail++;
          $display("FAIL all_req_order: grant %0d is ch %0d, expected %0d", i, grant_log[i], i % 4);
        end
      end
    end
  endtask

  task automatic test_stall();
    int start_cnt;
    apply_reset();
    start_cnt  = out_cnt;
    pidx       = 0;
    ready_mode = 1;
    drive_frame(1, 5, 0);
    settle("stall");
    ready_mode = 0;
    n_cmp++;
    if (out_cnt - start_cnt != 5) begin
      n_fail++;
      $display("FAIL stall_count: %0d bytes out, expected 5", out_cnt - start_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int tries;
    ch_req[0] = 1'b1;
    for (int b = 0; b < 2; b++) begin
      ch_data[0]  = 8'h50 + 8'(b);
      ch_src[0]   = 8'h05;
      ch_valid[0] = 1'b1;
      wait_accept(0, ok, tries);
    end
    ch_valid[0] = 1'b0;
    rst_n       = 1'b0;
    exp_q.delete();
    model_last  = NUM_CH - 1;
    model_cur   = 0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({merged_upload_req, merged_upload_valid, merged_upload_data, merged_upload_source,
         active_ch, in_upload_ready, dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: req=%b valid=%b data=%h src=%h ch=%0d ready=%b state=%0d, expected all 0",
               merged_upload_req, merged_upload_valid, merged_upload_data,
               merged_upload_source, active_ch, in_upload_ready, dbg_state);
    end
    ch_req[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    grant_log.delete();
    drive_frame(3, 2, 0);
    settle("reset_mid");
    n_cmp++;
    if (grant_log.size() != 1 || grant_log[0] !== 3'd3) begin
      n_fail++;
      $display("FAIL reset_mid_grant: %0d grants (first=%0d), expected one grant of ch 3",
               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : 3'd7);
    end
  endtask

  task automatic test_random();
    grant_log.delete();
    ready_mode = 2;
    fork
      chan_run(0, 3, 4, 2, 3);
      chan_run(1, 3, 4, 2, 3);
      chan_run(2, 3, 4, 2, 3);
      chan_run(3, 3, 4, 2, 3);
    join
    settle("random");
    ready_mode = 0;
    n_cmp++;
    if (grant_log.size() != 12) begin
      n_fail++;
      $display("FAIL random_grants: %0d grants, expected 12", grant_log.size());
    end
  endtask

`ifdef UPLOAD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cnt;
    apply_reset();
    grant_log.delete();
    ch_req[0] = 1'b1;
    fork
      drive_frame(1, 1, 0);
      begin
        cnt = 0;
        while (!merged_upload_req && cnt < 50) begin
          @(negedge clk);
          cnt++;
        end
        cnt = 0;
        do begin
          @(negedge clk);
          cnt++;
        end while (!timeout_flag && cnt < 100);
        n_cmp++;
        if (cnt != 16) begin
          n_fail++;
          $display("FAIL timeout_cycle: flag after %0d cycles, expected 16", cnt);
        end
        @(negedge clk);
        n_cmp++;
        if (timeout_flag !== 1'b0) begin
          n_fail++;
          $display("FAIL timeout_pulse: flag=%b one cycle later, expected 0", timeout_flag);
        end
        cnt = 0;
        while (grant_log.size() < 2 && cnt < 100) begin
          @(negedge clk);
          cnt++;
        end
        @(posedge clk);
        #1;
        ch_req[0] = 1'b0;
      end
    join
    settle("timeout");
    n_cmp++;
    if (grant_log.size() != 2 || grant_log[0] !== 3'd0 || grant_log[1] !== 3'd1) begin
      n_fail++;
      $display("FAIL timeout_regrant: %0d grants (second=%0d), expected 0 then 1",
               grant_log.size(), (grant_log.size() > 1) ? grant_log[1] : 3'd7);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_req[c]   = 1'b0;
      ch_valid[c] = 1'b0;
      ch_data[c]  = '0;
      ch_src[c]   = '0;
    end
    test_reset();
    test_single();
    test_two_req();
    test_all_req();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef UPLOAD_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
